// File: rtl/text_vmem_scroll.sv
// Text-mode character memory with write cursor, backspace/newline/wrap and ring-buffer scrolling.
// Optional cursor blink overlay when CURSOR_BLINK_EN is defined.
module text_vmem_scroll #(
  parameter int unsigned COLS   = 70,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned CHAR_W = 9,
  parameter int unsigned CHAR_H = 16,
  parameter int unsigned X_W    = 7,
  parameter int unsigned Y_W    = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     key_in,
  input  logic           p_valid,
  output logic           p_ready,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [9:0]     h_addr,
  input  logic [9:0]     v_addr,
  output logic [7:0]     ascii_out,
  output logic [3:0]     row,
  output logic [3:0]     col,
  output logic [X_W-1:0] cursor_x,
  output logic [Y_W-1:0] cursor_y
);

  localparam int unsigned Cells        = COLS * ROWS;
  localparam int unsigned AW           = $clog2(Cells);
  localparam logic [X_W-1:0] LastCol   = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] LastRow   = Y_W'(ROWS - 1);
  localparam logic [AW-1:0] LastCell   = AW'(Cells - 1);
  localparam logic [AW-1:0] LastLineCl = AW'(COLS - 1);
  localparam logic [X_W:0] ColsExt     = (X_W + 1)'(COLS);
  localparam logic [Y_W:0] RowsExt     = (Y_W + 1)'(ROWS);
  localparam logic [9:0] CharW10       = 10'(CHAR_W);
  localparam logic [9:0] CharH10       = 10'(CHAR_H);

  typedef enum logic [1:0] {StClearAll, StIdle, StClearLine} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  clr_q, clr_d;
  logic [X_W-1:0] cx_q, cx_d;
  logic [Y_W-1:0] cy_q, cy_d;
  logic [Y_W-1:0] top_q, top_d;

  logic [7:0]     mem [Cells];
  logic           we;
  logic [AW-1:0]  waddr;
  logic [7:0]     wdata;

  logic accept, key_print, key_enter, key_bs, newline;

  // Logical (column,row) to physical address through the ring-buffer top row.
  function automatic logic [AW-1:0] phys_addr(input logic [X_W-1:0] lx,
                                              input logic [Y_W-1:0] ly,
                                              input logic [Y_W-1:0] top);
    logic [Y_W:0] sum;
    sum = {1'b0, ly} + {1'b0, top};
    if (sum >= RowsExt) sum = sum - RowsExt;
    return AW'(sum) * AW'(COLS) + AW'(lx);
  endfunction

  assign accept    = p_valid && (state_q == StIdle);
  assign key_print = (key_in >= 8'h20) && (key_in <= 8'h7E);
  assign key_enter = (key_in == 8'h0D);
  assign key_bs    = (key_in == 8'h08);
  assign newline   = accept && ((key_print && (cx_q == LastCol)) || key_enter);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StClearAll;
      clr_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      top_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      top_q   <= top_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    top_d   = top_q;
    unique case (state_q)
      StClearAll: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == LastCell) begin
          clr_d   = '0;
          state_d = StIdle;
        end
      end
      StClearLine: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == LastLineCl) begin
          clr_d   = '0;
          state_d = StIdle;
          top_d   = (top_q == LastRow) ? '0 : top_q + 1'b1;
        end
      end
      StIdle: begin
        if (newline) begin
          cx_d = '0;
          if (cy_q != LastRow) begin
            cy_d = cy_q + 1'b1;
          end else begin
            clr_d   = '0;
            state_d = StClearLine;
          end
        end else if (accept && key_print) begin
          cx_d = cx_q + 1'b1;
        end else if (accept && key_bs) begin
          if (cx_q != '0) begin
            cx_d = cx_q - 1'b1;
          end else if (cy_q != '0) begin
            cx_d = LastCol;
            cy_d = cy_q - 1'b1;
          end
        end
      end
      default: state_d = StClearAll;
    endcase
  end

  always_comb begin
    p_ready = 1'b0;
    we      = 1'b0;
    waddr   = clr_q;
    wdata   = 8'h00;
    unique case (state_q)
      StClearAll: begin
        we    = 1'b1;
        waddr = clr_q;
      end
      StClearLine: begin
        we    = 1'b1;
        waddr = AW'(top_q) * AW'(COLS) + clr_q;
      end
      StIdle: begin
        p_ready = 1'b1;
        if (accept && key_print) begin
          we    = 1'b1;
          waddr = phys_addr(cx_q, cy_q, top_q);
          wdata = key_in;
        end else if (accept && key_bs && ((cx_q != '0) || (cy_q != '0))) begin
          // Backspace erases the cell the cursor moves back onto.
          we    = 1'b1;
          waddr = phys_addr(cx_d, cy_d, top_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we && reset) mem[waddr] <= wdata;
  end

  logic          rd_valid;
  logic [AW-1:0] raddr;
  logic [7:0]    rd_byte;
  logic          cursor_hit;
  logic [9:0]    row_full, col_full;
  logic          unused_pix;

`ifdef CURSOR_BLINK_EN
  localparam int unsigned BLINK_CYCLES = 12_500_000;
  logic [23:0] blink_q;
  logic        phase_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_q <= '0;
      phase_q <= 1'b0;
    end else if (blink_q == 24'(BLINK_CYCLES - 1)) begin
      blink_q <= '0;
      phase_q <= ~phase_q;
    end else begin
      blink_q <= blink_q + 1'b1;
    end
  end

  assign cursor_hit = phase_q && (x == cx_q) && (y == cy_q);
`else
  assign cursor_hit = 1'b0;
`endif

  assign rd_valid = ({1'b0, x} < ColsExt) && ({1'b0, y} < RowsExt);
  assign raddr    = phys_addr(x, y, top_q);
  assign row_full = v_addr - 10'(y) * CharH10;
  assign col_full = h_addr - 10'(x) * CharW10;
  assign unused_pix = ^{row_full[9:4], col_full[9:4]};

  always_comb begin
    rd_byte = 8'h00;
    if (rd_valid) rd_byte = mem[raddr];
    if (cursor_hit) rd_byte = 8'h5F;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ascii_out <= 8'h00;
      row       <= 4'h0;
      col       <= 4'h0;
    end else begin
      ascii_out <= rd_byte;
      row       <= row_full[3:0];
      col       <= col_full[3:0];
    end
  end

  assign cursor_x = cx_q;
  assign cursor_y = cy_q;

endmodule
